// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory between the icache (m0) and dcache (m1).
// One transaction is outstanding at a time; ack and read data route straight back to the owner.
module mem_arbiter #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_enable_i,
    input  logic                  m0_write_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    output logic                  m0_ack_o,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    input  logic                  m1_enable_i,
    input  logic                  m1_write_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    output logic                  m1_ack_o,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic                  mem_enable_o,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_ack_i,
    output logic [1:0]            grant_o,
    output logic [CNT_WIDTH-1:0]  m0_grants_o,
    output logic [CNT_WIDTH-1:0]  m1_grants_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_last;
    logic [CNT_WIDTH-1:0] r_m0Grants;
    logic [CNT_WIDTH-1:0] r_m1Grants;
    logic                 w_ack0;
    logic                 w_ack1;

    assign w_ack0 = (r_state == GRANT0) && mem_ack_i;
    assign w_ack1 = (r_state == GRANT1) && mem_ack_i;

    // r_last == 1 means m1 was served last, so m0 wins a tie.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (m0_enable_i && (!m1_enable_i || r_last)) begin
                    w_next = GRANT0;
                end else if (m1_enable_i) begin
                    w_next = GRANT1;
                end
            end
            GRANT0: begin
                if (mem_ack_i || !m0_enable_i) begin
                    w_next = IDLE;
                end
            end
            GRANT1: begin
                if (mem_ack_i || !m1_enable_i) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        grant_o      = 2'b00;
        m0_ack_o     = 1'b0;
        m1_ack_o     = 1'b0;
        case (r_state)
            GRANT0: begin
                mem_enable_o = m0_enable_i;
                mem_write_o  = m0_write_i;
                mem_addr_o   = m0_addr_i;
                mem_data_o   = m0_data_i;
                grant_o      = 2'b01;
                m0_ack_o     = mem_ack_i;
            end
            GRANT1: begin
                mem_enable_o = m1_enable_i;
                mem_write_o  = m1_write_i;
                mem_addr_o   = m1_addr_i;
                mem_data_o   = m1_data_i;
                grant_o      = 2'b10;
                m1_ack_o     = mem_ack_i;
            end
            default: ;
        endcase
    end

    assign m0_data_o   = mem_data_i;
    assign m1_data_o   = mem_data_i;
    assign m0_grants_o = r_m0Grants;
    assign m1_grants_o = r_m1Grants;

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_m0Grants <= '0;
            r_m1Grants <= '0;
        end else begin
            r_state <= w_next;
            if (w_ack0) begin
                r_last <= 1'b0;
                if (r_m0Grants != {CNT_WIDTH{1'b1}}) begin
                    r_m0Grants <= r_m0Grants + CNT_WIDTH'(1);
                end
            end
            if (w_ack1) begin
                r_last <= 1'b1;
                if (r_m1Grants != {CNT_WIDTH{1'b1}}) begin
                    r_m1Grants <= r_m1Grants + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal checks plus a per-cycle
// transaction-level ownership model compared against every output.
module tb_mem_arbiter;

    localparam int DW = 256;
    localparam int AW = 32;
    localparam int CW = 2;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          m0En = 1'b0, m0Wr = 1'b0, m1En = 1'b0, m1Wr = 1'b0;
    logic [AW-1:0] m0Addr = '0, m1Addr = '0;
    logic [DW-1:0] m0Wdata = '0, m1Wdata = '0;
    logic [DW-1:0] memRdata = '0;
    logic          memAck = 1'b0;

    logic          m0_ack_o, m1_ack_o, mem_enable_o, mem_write_o;
    logic [DW-1:0] m0_data_o, m1_data_o, mem_data_o;
    logic [AW-1:0] mem_addr_o;
    logic [1:0]    grant_o;
    logic [CW-1:0] m0_grants_o, m1_grants_o;

    int nCompared = 0;
    int nMismatched = 0;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_enable_i(m0En), .m0_write_i(m0Wr), .m0_addr_i(m0Addr), .m0_data_i(m0Wdata),
        .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
        .m1_enable_i(m1En), .m1_write_i(m1Wr), .m1_addr_i(m1Addr), .m1_data_i(m1Wdata),
        .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(memRdata), .mem_ack_i(memAck),
        .grant_o(grant_o), .m0_grants_o(m0_grants_o), .m1_grants_o(m1_grants_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int p, input logic en, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        if (p == 0) begin
            m0En = en; m0Wr = wr; m0Addr = addr; m0Wdata = data;
        end else begin
            m1En = en; m1Wr = wr; m1Addr = addr; m1Wdata = data;
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Uncontested transaction: request, wait lat cycles, ack with rdata, release.
    task automatic doTxn(input int p, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int lat, input logic [DW-1:0] rdata);
        applyStimulus(p, 1'b1, wr, addr, wdata);
        tick();
        checkOutput("txn_grant", DW'(grant_o), (p == 0) ? DW'(2'b01) : DW'(2'b10));
        tick(lat);
        memAck = 1'b1;
        memRdata = rdata;
        #1;
        checkOutput("txn_ack", DW'((p == 0) ? m0_ack_o : m1_ack_o), DW'(1));
        tick();
        memAck = 1'b0;
        applyStimulus(p, 1'b0, 1'b0, '0, '0);
    endtask

    // Ownership model: owner is -1 when idle, else the port index holding the memory.
    int            owner = -1;
    int            lastServed = 1;
    int            cnt [2] = '{0, 0};
    localparam int CNT_MAX = (1 << CW) - 1;

    always @(negedge clk_i) begin
        logic          en [2];
        logic          wr [2];
        logic [AW-1:0] ad [2];
        logic [DW-1:0] dt [2];
        logic          expAck [2];
        en = '{m0En, m1En};
        wr = '{m0Wr, m1Wr};
        ad = '{m0Addr, m1Addr};
        dt = '{m0Wdata, m1Wdata};
        if (!rst_i) begin
            owner = -1;
            lastServed = 1;
            cnt = '{0, 0};
        end
        expAck = '{1'b0, 1'b0};
        if (owner >= 0) expAck[owner] = memAck;
        checkOutput("grant", DW'(grant_o), (owner < 0) ? DW'(0) : DW'(1 << owner));
        checkOutput("mem_enable", DW'(mem_enable_o), (owner < 0) ? DW'(0) : DW'(en[owner]));
        checkOutput("mem_write", DW'(mem_write_o), (owner < 0) ? DW'(0) : DW'(wr[owner]));
        checkOutput("mem_addr", DW'(mem_addr_o), (owner < 0) ? DW'(0) : DW'(ad[owner]));
        checkOutput("mem_data", mem_data_o, (owner < 0) ? DW'(0) : dt[owner]);
        checkOutput("m0_ack", DW'(m0_ack_o), DW'(expAck[0]));
        checkOutput("m1_ack", DW'(m1_ack_o), DW'(expAck[1]));
        checkOutput("m0_data", m0_data_o, memRdata);
        checkOutput("m1_data", m1_data_o, memRdata);
        checkOutput("m0_grants", DW'(m0_grants_o), DW'(cnt[0]));
        checkOutput("m1_grants", DW'(m1_grants_o), DW'(cnt[1]));
        if (rst_i) begin
            if (owner < 0) begin
                if (en[0] && en[1]) owner = 1 - lastServed;
                else if (en[0]) owner = 0;
                else if (en[1]) owner = 1;
            end else if (memAck) begin
                lastServed = owner;
                if (cnt[owner] < CNT_MAX) cnt[owner] = cnt[owner] + 1;
                owner = -1;
            end else if (!en[owner]) begin
                owner = -1;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int satExp [5] = '{1, 2, 3, 3, 3};

        // Reset state
        #2;
        checkOutput("reset_grant", DW'(grant_o), DW'(0));
        checkOutput("reset_mem_enable", DW'(mem_enable_o), DW'(0));
        checkOutput("reset_m0_grants", DW'(m0_grants_o), DW'(0));
        tick(2);
        rst_i = 1'b1;
        tick();

        // Solo read by m1
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0400, '0);
        tick();
        checkOutput("solo_grant", DW'(grant_o), DW'(2'b10));
        checkOutput("solo_addr", DW'(mem_addr_o), DW'(32'h400));
        tick(10);
        memAck = 1'b1;
        memRdata = {8{32'hCAFE_0400}};
        #1;
        checkOutput("solo_m1_ack", DW'(m1_ack_o), DW'(1));
        checkOutput("solo_m0_ack", DW'(m0_ack_o), DW'(0));
        checkOutput("solo_m1_data", m1_data_o, {8{32'hCAFE_0400}});
        tick();
        memAck = 1'b0;
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        #1;
        checkOutput("solo_m1_ack_gone", DW'(m1_ack_o), DW'(0));
        checkOutput("solo_m1_grants", DW'(m1_grants_o), DW'(1));
        tick();

        // Tie: m0 first, bubble, then m1, then next tie to m0
        applyStimulus(0, 1'b1, 1'b0, 32'h100, '0);
        applyStimulus(1, 1'b1, 1'b0, 32'h200, '0);
        tick();
        checkOutput("tie_first_m0", DW'(grant_o), DW'(2'b01));
        tick(2);
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        checkOutput("tie_bubble", DW'(mem_enable_o), DW'(0));
        tick();
        checkOutput("tie_then_m1", DW'(grant_o), DW'(2'b10));
        tick();
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        tick();
        applyStimulus(0, 1'b1, 1'b0, 32'h140, '0);
        applyStimulus(1, 1'b1, 1'b0, 32'h240, '0);
        tick();
        checkOutput("tie_again_m0", DW'(grant_o), DW'(2'b01));
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        tick();

        // Writeback then refill with m0 waiting from mid-writeback
        applyStimulus(1, 1'b1, 1'b1, 32'h800, {8{32'hD1D1_0800}});
        tick();
        checkOutput("wb_grant_m1", DW'(grant_o), DW'(2'b10));
        checkOutput("wb_write", DW'(mem_write_o), DW'(1));
        tick(2);
        applyStimulus(0, 1'b1, 1'b0, 32'h100, '0);
        tick(2);
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        applyStimulus(1, 1'b1, 1'b0, 32'hC00, '0);
        checkOutput("wb_bubble", DW'(grant_o), DW'(0));
        tick();
        checkOutput("wb_then_m0", DW'(grant_o), DW'(2'b01));
        checkOutput("wb_m0_read", DW'(mem_write_o), DW'(0));
        tick(2);
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        tick();
        checkOutput("refill_m1", DW'(grant_o), DW'(2'b10));
        checkOutput("refill_addr", DW'(mem_addr_o), DW'(32'hC00));
        checkOutput("refill_read", DW'(mem_write_o), DW'(0));
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        tick();

        // Abort and stray ack in idle
        applyStimulus(0, 1'b1, 1'b0, 32'h300, '0);
        tick();
        checkOutput("abort_grant", DW'(grant_o), DW'(2'b01));
        applyStimulus(0, 1'b0, 1'b0, 32'h300, '0);
        #1;
        checkOutput("abort_enable_drop", DW'(mem_enable_o), DW'(0));
        tick();
        checkOutput("abort_idle", DW'(grant_o), DW'(0));
        memAck = 1'b1;
        #1;
        checkOutput("stray_m0_ack", DW'(m0_ack_o), DW'(0));
        checkOutput("stray_m1_ack", DW'(m1_ack_o), DW'(0));
        tick();
        memAck = 1'b0;
        tick();

        // Reset mid-transaction
        applyStimulus(1, 1'b1, 1'b0, 32'h500, '0);
        tick();
        checkOutput("rstmid_grant", DW'(grant_o), DW'(2'b10));
        rst_i = 1'b0;
        #1;
        checkOutput("rstmid_grant_clr", DW'(grant_o), DW'(0));
        checkOutput("rstmid_enable_clr", DW'(mem_enable_o), DW'(0));
        checkOutput("rstmid_m1_grants", DW'(m1_grants_o), DW'(0));
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        tick(2);
        rst_i = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 32'h600, '0);
        applyStimulus(1, 1'b1, 1'b0, 32'h700, '0);
        tick();
        checkOutput("rstmid_tie_m0", DW'(grant_o), DW'(2'b01));
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        tick();

        // Saturation of the 2-bit m0 counter
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            doTxn(0, 1'b0, AW'(32'h1000 + i * 32), '0, 1 + i, {8{32'h5A5A_0000 + 32'(i)}});
            checkOutput("sat_m0_grants", DW'(m0_grants_o), DW'(satExp[i]));
        end
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer that shares the single 256-bit line-wide data memory between the instruction-side cache (port m0) and the data cache (port m1). It sits between both cache controllers and the memory model. It grants exactly one outstanding line transaction at a time under round-robin priority, and routes the memory acknowledge and read data back to the owner. Per-port grant counters are provided for performance debug.

## Interface
Parameters:
- DATA_WIDTH, 256: line width in bits.
- ADDR_WIDTH, 32: byte address width.
- CNT_WIDTH, 16: width of each saturating grant counter.

Ports (one clock; reset is asynchronous and active-low):
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- m0_enable_i  input  1  port-0 request; held high until acked.
- m0_write_i  input  1  port-0 write (1) / read (0).
- m0_addr_i  input  ADDR_WIDTH  port-0 line address.
- m0_data_i  input  DATA_WIDTH  port-0 write data.
- m0_ack_o  output  1  port-0 acknowledge pulse.
- m0_data_o  output  DATA_WIDTH  port-0 read data.
- m1_enable_i, m1_write_i, m1_addr_i, m1_data_i, m1_ack_o, m1_data_o: same widths and directions as port 0, for port 1.
- mem_enable_o  output  1  memory request.
- mem_write_o  output  1  memory write.
- mem_addr_o  output  ADDR_WIDTH  memory address.
- mem_data_o  output  DATA_WIDTH  memory write data.
- mem_data_i  input  DATA_WIDTH  memory read data.
- mem_ack_i  input  1  memory acknowledge, one-cycle pulse.
- grant_o  output  2  one-hot current owner; 0 when idle.
- m0_grants_o, m1_grants_o  output  CNT_WIDTH  completed-transaction counts, saturating.

## Operation
- States: IDLE, GRANT0, GRANT1. Registers: state, last (last port served), two counters.
- IDLE:
  - Only m0 requesting: go to GRANT0.
  - Only m1 requesting: go to GRANT1.
  - Both requesting: grant the port not equal to last.
  - Neither requesting: stay in IDLE.
- GRANTx:
  - mem_enable_o, mem_write_o, mem_addr_o and mem_data_o are a combinational mux of port x's inputs.
  - mem_enable_o = mx_enable_i, so it is 0 if port x drops its request.
- Acknowledge:
  - In GRANTx, mx_ack_o = mem_ack_i, combinationally.
  - The other port's ack is always 0.
  - On the ack edge: state goes to IDLE, last is set to x, and mx_grants increments. A counter already at all-ones holds its value.
- Abort: in GRANTx with mx_enable_i low and mem_ack_i low, go to IDLE at that edge. last and the counters are unchanged.
- mem_ack_i is ignored in IDLE; no port sees it.
- m0_data_o and m1_data_o both equal mem_data_i at all times. Ports qualify the data with their own ack.
- Idle outputs: mem_enable_o, mem_write_o and grant_o are 0. mem_addr_o and mem_data_o are driven 0.
- Reset (async, any state): state goes to IDLE, last to 1 so m0 wins the first tie, and both counters to 0. All outputs take their idle values immediately.

## Timing
- Arbitration latency: 1 cycle. A request first seen high in cycle n gives mem_enable_o high in cycle n+1, when the memory is free.
- Ack path is zero latency: mem_ack_i to mx_ack_o is combinational.
- Ack in cycle k: the port owns the memory through cycle k. Cycle k+1 is IDLE with mem_enable_o = 0, giving a mandatory one-cycle bubble. The next grant's mem_enable_o appears in cycle k+2.
- A port that keeps its request high through the ack (dcache writeback followed by refill) re-arbitrates in cycle k+1. It loses to a waiting opposite port because of round-robin order.
- Requesters must hold enable, write, addr and data stable from request until ack. The arbiter does not latch them.
- Maximum wait for a continuously requesting port: one full transaction of the other port plus 2 cycles.

## Test plan
- Solo read: m1 read at addr 0x0000_0400, memory acks 10 cycles after mem_enable_o rises -> grant_o = 2'b10 from the next cycle. mem_addr_o = 0x400. m1_ack_o pulses for exactly 1 cycle with m1_data_o = mem_data_i. m0_ack_o stays 0. m1_grants_o = 1.
- Tie after reset: m0 and m1 raise requests in the same cycle -> m0 is served first. After m0's ack: 1 idle cycle, then m1 is granted. Next tie goes to m0.
- Writeback then refill: m1 write (dirty line, addr 0x800) then read (addr 0xC00) with enable held across the ack, while m0 waits from mid-writeback -> order is m1-write, m0, m1-read. mem_write_o is 1 only during the m1-write grant.
- Abort: m0 granted, m0_enable_i drops before any ack -> mem_enable_o falls in the same cycle, state is IDLE next cycle, m0_grants_o unchanged. A stray mem_ack_i in IDLE produces no port ack.
- Reset mid-transaction: rst_i low during GRANT1 -> grant_o = 0 and mem_enable_o = 0 immediately, counters = 0. After release, the first tie goes to m0.
- Saturation: CNT_WIDTH = 2, run 5 m0 transactions -> m0_grants_o reads 1, 2, 3, 3, 3.
